intr_ctrl: RTL

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 27 ++
 rtl/intr_prio_sel.sv | 23 ++
 rtl/intr_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, source count
// and the per-source exception vectors.
package intr_ctrl_pkg;

    localparam int unsigned NUM_SRC = 4;

    localparam logic [31:0] VEC_SRC0 = 32'h0000002C;
    localparam logic [31:0] VEC_SRC1 = 32'h00000004;
    localparam logic [31:0] VEC_SRC2 = 32'h00000008;
    localparam logic [31:0] VEC_SRC3 = 32'h0000000C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    function automatic logic [31:0] src_vector(input logic [1:0] idx);
        case (idx)
            2'd0:    src_vector = VEC_SRC0;
            2'd1:    src_vector = VEC_SRC1;
            2'd2:    src_vector = VEC_SRC2;
            default: src_vector = VEC_SRC3;
        endcase
    endfunction

endpackage

// File: rtl/intr_prio_sel.sv
// Fixed-priority selector: lowest-index eligible source wins.
module intr_prio_sel
    import intr_ctrl_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible,
    output logic [1:0]         idx,
    output logic               valid,
    output logic [31:0]        vec
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && !valid) begin
                valid = 1'b1;
                idx   = 2'(i);
            end
        end
        vec = valid ? src_vector(idx) : '0;
    end

endmodule

// File: rtl/intr_ctrl.sv
// Four-source interrupt controller: sticky pending/overflow flags, maskable
// fixed-priority arbitration and an IDLE/REQ/SERVICE handshake with the CPU.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_EADDR = 32'h00000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] done,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               irq_ack,
    input  logic               eret,
    input  logic               ovf_clr,
    output logic               irq,
    output logic [31:0]        EAddr,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service,
    output logic [NUM_SRC-1:0] ovf
);

    state_t               state, state_n;
    logic [1:0]           winner, winner_n;
    logic [31:0]          eaddr_n;
    logic [NUM_SRC-1:0]   insv_n;
    logic [NUM_SRC-1:0]   mask;
    logic [NUM_SRC-1:0]   clr;
    logic [NUM_SRC-1:0]   ovf_set;
    logic [1:0]           sel_idx;
    logic                 sel_valid;
    logic [31:0]          sel_vec;

    // Arbitration sees the mask as it was before any write in this cycle.
    intr_prio_sel u_sel (
        .eligible (pending & mask),
        .idx      (sel_idx),
        .valid    (sel_valid),
        .vec      (sel_vec)
    );

    always_comb begin
        state_n  = state;
        winner_n = winner;
        eaddr_n  = EAddr;
        insv_n   = in_service;
        clr      = '0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_n  = ST_REQ;
                    winner_n = sel_idx;
                    eaddr_n  = sel_vec;
                end
            end
            ST_REQ: begin
                // Ack is checked first so it wins over a same-cycle retraction.
                if (irq_ack) begin
                    state_n     = ST_SERVICE;
                    clr[winner] = 1'b1;
                    insv_n      = '0;
                    insv_n[winner] = 1'b1;
                end else if (!mask[winner]) begin
                    state_n = ST_IDLE;
                    eaddr_n = RESET_EADDR;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_n = ST_IDLE;
                    insv_n  = '0;
                    eaddr_n = RESET_EADDR;
                end
            end
            default: begin
                state_n = ST_IDLE;
                insv_n  = '0;
                eaddr_n = RESET_EADDR;
            end
        endcase
    end

    assign ovf_set = done & pending & ~clr;
    assign irq     = (state == ST_REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            winner     <= '0;
            EAddr      <= RESET_EADDR;
            in_service <= '0;
            pending    <= '0;
            ovf        <= '0;
            mask       <= '1;
        end else begin
            state      <= state_n;
            winner     <= winner_n;
            EAddr      <= eaddr_n;
            in_service <= insv_n;
            pending    <= (pending & ~clr) | done;
            ovf        <= (ovf_clr ? '0 : ovf) | ovf_set;
            if (mask_we)
                mask <= mask_wdata;
        end
    end

endmodule
